pwm_compare_8b: RTL and testbench
=================================

# pwm_compare_8b

Downstream consumer of the 8-bit up/down counter. Compares the free-running count against a double-buffered duty value and produces a registered PWM output. Duty updates are deferred to the counter's wrap boundary (FF→00 counting up, 00→FF counting down), so every PWM period is glitch-free. A one-cycle period strobe is also emitted for firmware and other stages.

## Interface
- INVERT, 0, output polarity: 0 = active-high PWM, 1 = active-low (idle level = INVERT)

- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- count  input  8  counter value from the up/down counter, sampled each clk
- en  input  1  PWM enable; low forces pwm_out to idle level
- duty_in  input  8  new duty value
- duty_wr  input  1  single-cycle write strobe for duty_in
- pwm_out  output  1  registered PWM output
- period_pulse  output  1  one-cycle strobe, high in the cycle after a wrap is detected
- duty_active  output  8  duty value currently used for comparison
- pending  output  1  a written duty is waiting for the next wrap

## Operation
- Internal state: count_q[7:0] (previous count), primed (count_q valid), duty_pend[7:0], pending, duty_active, pwm_out, period_pulse.
- The first clk after reset only loads count_q and sets primed. No wrap can be detected in that cycle.
- wrap = primed && ((count_q==8'hFF && count==8'h00) || (count_q==8'h00 && count==8'hFF)).
- Any other jump, including the counter being reset from a mid value to 0, is not a wrap. Period boundaries come only from the two wrap transitions.
- duty_wr: duty_pend <= duty_in and pending <= 1. Multiple writes before a wrap: the last one wins.
- On wrap with pending=1: duty_active <= duty_pend and pending <= 0. On wrap with pending=0: duty_active is unchanged.
- duty_wr in the same cycle as wrap: the old duty_pend is applied, and duty_in becomes the new duty_pend with pending=1. It takes effect at the following wrap.
- duty_next = (wrap && pending) ? duty_pend : duty_active.
- pwm_out <= en ? ((count < duty_next) ^ INVERT) : INVERT. The comparison is unsigned 8-bit.
- Duty boundary values:
  - duty 8'h00: output is never active.
  - duty 8'hFF: output is active for count 00..FE and inactive at FF.
  - duty D gives D active clocks per 256-count period, for both directions.
- en does not gate wrap detection, duty buffering, or period_pulse.
- period_pulse <= wrap.

## Timing
- Reset values:
  - pwm_out = INVERT
  - period_pulse = 0, duty_active = 8'h00, pending = 0
  - count_q = 8'h00, primed = 0
- Latency count → pwm_out: 1 clk (registered).
- Wrap visible on count at edge t: period_pulse is high during cycle t+1, and duty_active is updated at edge t.
- The first PWM cycle of the new period already uses the new duty.
- duty_wr at edge t: pending = 1 from t+1.
- Reset assertion mid-period drops all outputs to their reset values immediately (asynchronous). After release, primed is required again before any wrap.

## Structure
- Shared package pwm_pkg:
  - CNT_W = 8, CNT_MAX = 8'hFF, CNT_MIN = 8'h00
  - a localparam function for the idle level
- Sub-module wrap_detect: holds count_q and primed, and outputs wrap. It is reusable by other counter consumers.
- The top level holds the duty buffer, comparator and output registers.

## Test plan
- Reset mid-operation (rst_n low while pwm_out is active, duty_active = 8'h40) → pwm_out = 0, duty_active = 8'h00, pending = 0 immediately.
- Up-count, duty_wr 8'h40 at count 8'h10:
  - pending = 1 and duty_active stays 8'h00 until FF→00.
  - period_pulse is high for exactly 1 clk after the wrap.
  - Then pwm_out is high for 64 clks and low for 192 clks, repeating.
- Writes of 8'h20 then 8'h80 in one period → only 8'h80 is applied at the wrap; 128 high clocks per period.
- Down-count across 00→FF with duty_pend = 8'h10 → period_pulse asserts and duty_active = 8'h10. pwm_out goes high for counts 0F..00, i.e. 16 clks.
- Duty boundary values:
  - duty 8'h00 → pwm_out stays 0 for a full 256-clk period.
  - duty 8'hFF → pwm_out is low only in the clk after count = 8'hFF.
- Gating and collisions:
  - en dropped mid-period → pwm_out reaches idle on the next clk, while period_pulse keeps firing every 256 clks.
  - duty_wr coincident with wrap → old pending value is applied, and the new value shows pending = 1 until the following wrap.
  - INVERT = 1 regression of the up-count scenario → all pwm_out levels are complemented.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared counter constants and idle-level helper for PWM stages
package pwm_pkg;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MIN = 8'h00;
  function automatic logic idle_level(input logic invert);
    return invert;
  endfunction
endpackage

// File: rtl/pwm_compare_8b_wrap_detect.sv
// wrap_detect: flags FF->00 and 00->FF counter transitions once a previous sample exists
module wrap_detect
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_wrap
);
  logic [CNT_W-1:0] r_count_q;
  logic             r_primed;
  // remember the previous count; primed marks the sample as valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_count_q <= CNT_MIN;
      r_primed  <= 1'b0;
    end else begin
      r_count_q <= i_count;
      r_primed  <= 1'b1;
    end
  assign o_wrap = r_primed && ((r_count_q == CNT_MAX && i_count == CNT_MIN) ||
                               (r_count_q == CNT_MIN && i_count == CNT_MAX));
endmodule

// File: rtl/pwm_compare_8b.sv
// pwm_compare_8b: double-buffered duty compare against a free-running count
module pwm_compare_8b
  import pwm_pkg::*;
#(
  parameter logic INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_duty_in,
  input  logic             i_duty_wr,
  output logic             o_pwm_out,
  output logic             o_period_pulse,
  output logic [CNT_W-1:0] o_duty_active,
  output logic             o_pending
);
  localparam logic IDLE = idle_level(INVERT);
  logic             w_wrap;
  logic [CNT_W-1:0] w_duty_next;
  logic [CNT_W-1:0] r_duty_pend;
  logic [CNT_W-1:0] r_duty_active;
  logic             r_pending;
  logic             r_pwm;
  logic             r_pulse;
  wrap_detect u_wrap (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_count(i_count),
    .o_wrap (w_wrap)
  );
  assign w_duty_next = (w_wrap && r_pending) ? r_duty_pend : r_duty_active;
  // buffer duty writes, promote them at wraps, and register the compare result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_duty_pend   <= CNT_MIN;
      r_duty_active <= CNT_MIN;
      r_pending     <= 1'b0;
      r_pwm         <= IDLE;
      r_pulse       <= 1'b0;
    end else begin
      if (i_duty_wr) r_duty_pend <= i_duty_in;
      r_pending     <= i_duty_wr ? 1'b1 : (w_wrap ? 1'b0 : r_pending);
      r_duty_active <= w_duty_next;
      r_pwm         <= i_en ? ((i_count < w_duty_next) ^ INVERT) : IDLE;
      r_pulse       <= w_wrap;
    end
  assign o_pwm_out      = r_pwm;
  assign o_period_pulse = r_pulse;
  assign o_duty_active  = r_duty_active;
  assign o_pending      = r_pending;
endmodule

// File: tb/tb_pwm_compare_8b.sv
// tb_pwm_compare_8b: directed checks of duty buffering, wraps, boundaries and polarity
module tb_pwm_compare_8b;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] count = 8'h00;
  logic       en = 1'b0;
  logic [7:0] duty_in = 8'h00;
  logic       duty_wr = 1'b0;
  logic       pwm, pulse, pend, pwm_i, pulse_i, pend_i;
  logic [7:0] act, act_i;
  int vectors = 0;
  int errors = 0;

  pwm_compare_8b #(.INVERT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .i_count(count), .i_en(en), .i_duty_in(duty_in),
    .i_duty_wr(duty_wr), .o_pwm_out(pwm), .o_period_pulse(pulse),
    .o_duty_active(act), .o_pending(pend)
  );
  pwm_compare_8b #(.INVERT(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .i_count(count), .i_en(en), .i_duty_in(duty_in),
    .i_duty_wr(duty_wr), .o_pwm_out(pwm_i), .o_period_pulse(pulse_i),
    .o_duty_active(act_i), .o_pending(pend_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cnt(input bit up, input logic [7:0] target);
    for (int i = 0; i < 256 && count != target; i++) begin
      count = up ? count + 8'd1 : count - 8'd1;
      step();
    end
  endtask

  task automatic run(input bit up, input int n, output int hi, output int hi_inv, output int pulses);
    hi = 0; hi_inv = 0; pulses = 0;
    for (int i = 0; i < n; i++) begin
      count = up ? count + 8'd1 : count - 8'd1;
      step();
      hi += pwm ? 1 : 0;
      hi_inv += pwm_i ? 1 : 0;
      pulses += pulse ? 1 : 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    vectors++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
    vectors++; if (pwm_i !== 1'b1) begin errors++; $display("FAIL reset_pwm_inv: got %b expected 1", pwm_i); end
    vectors++; if ({pulse, pend, act} !== 10'h000) begin errors++; $display("FAIL reset_state: got pulse=%b pend=%b act=%h expected 0/0/00", pulse, pend, act); end
    rst_n = 1'b1;
  endtask

  task automatic test_up_count();
    int h, hv, p;
    en = 1'b1;
    count = 8'h08;
    step();
    goto_cnt(1'b1, 8'h0F);
    count = 8'h10; duty_in = 8'h40; duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    vectors++; if (pend !== 1'b1 || act !== 8'h00) begin errors++; $display("FAIL up_write: got pend=%b act=%h expected 1/00", pend, act); end
    goto_cnt(1'b1, 8'hFF);
    vectors++; if (pend !== 1'b1 || act !== 8'h00 || pwm !== 1'b0) begin errors++; $display("FAIL up_hold: got pend=%b act=%h pwm=%b expected 1/00/0", pend, act, pwm); end
    count = 8'h00;
    step();
    vectors++; if (pulse !== 1'b1 || act !== 8'h40 || pend !== 1'b0 || pwm !== 1'b1) begin errors++; $display("FAIL up_wrap: got pulse=%b act=%h pend=%b pwm=%b expected 1/40/0/1", pulse, act, pend, pwm); end
    run(1'b1, 255, h, hv, p);
    vectors++; if (h !== 63 || hv !== 192 || p !== 0) begin errors++; $display("FAIL up_first_period: got hi=%0d hi_inv=%0d pulses=%0d expected 63/192/0", h, hv, p); end
    run(1'b1, 256, h, hv, p);
    vectors++; if (h !== 64 || hv !== 192 || p !== 1) begin errors++; $display("FAIL up_second_period: got hi=%0d hi_inv=%0d pulses=%0d expected 64/192/1", h, hv, p); end
  endtask

  task automatic test_async_reset();
    int h, hv, p;
    run(1'b1, 6, h, hv, p);
    vectors++; if (pwm !== 1'b1 || act !== 8'h40) begin errors++; $display("FAIL pre_reset: got pwm=%b act=%h expected 1/40", pwm, act); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (pwm !== 1'b0 || pwm_i !== 1'b1 || act !== 8'h00 || pend !== 1'b0 || pulse !== 1'b0) begin errors++; $display("FAIL async_reset: got pwm=%b inv=%b act=%h pend=%b pulse=%b expected 0/1/00/0/0", pwm, pwm_i, act, pend, pulse); end
    step();
    rst_n = 1'b1;
    count = 8'hFF;
    step();
    vectors++; if (pulse !== 1'b0) begin errors++; $display("FAIL unprimed_wrap: got pulse=%b expected 0", pulse); end
    count = 8'h00;
    step();
    vectors++; if (pulse !== 1'b1) begin errors++; $display("FAIL primed_wrap: got pulse=%b expected 1", pulse); end
    count = 8'h80;
    step();
    count = 8'h00;
    step();
    vectors++; if (pulse !== 1'b0) begin errors++; $display("FAIL jump_not_wrap: got pulse=%b expected 0", pulse); end
  endtask

  task automatic test_last_write_wins();
    int h, hv, p;
    goto_cnt(1'b1, 8'h1F);
    count = 8'h20; duty_in = 8'h20; duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    goto_cnt(1'b1, 8'h7F);
    count = 8'h80; duty_in = 8'h80; duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    vectors++; if (pend !== 1'b1 || act !== 8'h00) begin errors++; $display("FAIL double_write: got pend=%b act=%h expected 1/00", pend, act); end
    goto_cnt(1'b1, 8'hFF);
    run(1'b1, 256, h, hv, p);
    vectors++; if (h !== 128 || p !== 1 || act !== 8'h80) begin errors++; $display("FAIL last_wins: got hi=%0d pulses=%0d act=%h expected 128/1/80", h, p, act); end
  endtask

  task automatic test_down_count();
    int h, hv, p;
    count = 8'hFE; duty_in = 8'h10; duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    goto_cnt(1'b0, 8'h00);
    vectors++; if (pend !== 1'b1 || act !== 8'h80 || pulse !== 1'b0) begin errors++; $display("FAIL down_hold: got pend=%b act=%h pulse=%b expected 1/80/0", pend, act, pulse); end
    count = 8'hFF;
    step();
    vectors++; if (pulse !== 1'b1 || act !== 8'h10 || pend !== 1'b0 || pwm !== 1'b0) begin errors++; $display("FAIL down_wrap: got pulse=%b act=%h pend=%b pwm=%b expected 1/10/0/0", pulse, act, pend, pwm); end
    run(1'b0, 255, h, hv, p);
    vectors++; if (h !== 16 || hv !== 239 || p !== 0) begin errors++; $display("FAIL down_period: got hi=%0d hi_inv=%0d pulses=%0d expected 16/239/0", h, hv, p); end
  endtask

  task automatic test_duty_zero();
    int h, hv, p;
    count = 8'h01; duty_in = 8'h00; duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    goto_cnt(1'b1, 8'hFF);
    run(1'b1, 256, h, hv, p);
    vectors++; if (h !== 0 || p !== 1 || act !== 8'h00) begin errors++; $display("FAIL duty_zero: got hi=%0d pulses=%0d act=%h expected 0/1/00", h, p, act); end
  endtask

  task automatic test_duty_full();
    int h, hv, p;
    goto_cnt(1'b1, 8'h10);
    count = 8'h11; duty_in = 8'hFF; duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    goto_cnt(1'b1, 8'hFF);
    run(1'b1, 255, h, hv, p);
    vectors++; if (h !== 255 || act !== 8'hFF) begin errors++; $display("FAIL duty_full: got hi=%0d act=%h expected 255/ff", h, act); end
    count = 8'hFF;
    step();
    vectors++; if (pwm !== 1'b0) begin errors++; $display("FAIL duty_full_ff: got pwm=%b expected 0", pwm); end
  endtask

  task automatic test_en_gating();
    int h, hv, p;
    goto_cnt(1'b1, 8'h80);
    vectors++; if (pwm !== 1'b1) begin errors++; $display("FAIL en_before: got pwm=%b expected 1", pwm); end
    en = 1'b0;
    count = 8'h81;
    step();
    vectors++; if (pwm !== 1'b0 || pwm_i !== 1'b1) begin errors++; $display("FAIL en_idle: got pwm=%b inv=%b expected 0/1", pwm, pwm_i); end
    run(1'b1, 512, h, hv, p);
    vectors++; if (h !== 0 || hv !== 512 || p !== 2) begin errors++; $display("FAIL en_pulses: got hi=%0d hi_inv=%0d pulses=%0d expected 0/512/2", h, hv, p); end
    en = 1'b1;
  endtask

  task automatic test_collision();
    int h, hv, p;
    goto_cnt(1'b1, 8'h10);
    count = 8'h11; duty_in = 8'h30; duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    goto_cnt(1'b1, 8'hFF);
    count = 8'h00; duty_in = 8'h60; duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    vectors++; if (pulse !== 1'b1 || act !== 8'h30 || pend !== 1'b1 || pwm !== 1'b1) begin errors++; $display("FAIL collide_wrap: got pulse=%b act=%h pend=%b pwm=%b expected 1/30/1/1", pulse, act, pend, pwm); end
    run(1'b1, 255, h, hv, p);
    vectors++; if (h !== 47 || act !== 8'h30 || pend !== 1'b1) begin errors++; $display("FAIL collide_period: got hi=%0d act=%h pend=%b expected 47/30/1", h, act, pend); end
    count = 8'h00;
    step();
    vectors++; if (act !== 8'h60 || pend !== 1'b0 || pulse !== 1'b1) begin errors++; $display("FAIL collide_next: got act=%h pend=%b pulse=%b expected 60/0/1", act, pend, pulse); end
  endtask

  task automatic test_invert();
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      count = count + 8'd1;
      step();
      if (pwm_i !== ~pwm) bad++;
    end
    vectors++; if (bad !== 0) begin errors++; $display("FAIL invert_complement: got %0d uncomplemented cycles expected 0", bad); end
    vectors++; if (act_i !== 8'h60 || pulse_i !== pulse || pend_i !== pend) begin errors++; $display("FAIL invert_state: got act=%h pulse=%b pend=%b expected 60/%b/%b", act_i, pulse_i, pend_i, pulse, pend); end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_async_reset();
    test_last_write_wins();
    test_down_count();
    test_duty_zero();
    test_duty_full();
    test_en_gating();
    test_collision();
    test_invert();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
